reg_writeback_queue: RTL

//  Write-side initiator for the 16x8 register file: sole driver of its reg_write/rd/write_data port.

---
 rtl/reg_writeback_queue.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/reg_writeback_queue.sv
// Regfile write-port arbiter: core ALU results take absolute priority; crypto results queue in a DEPTH-entry FIFO.
// Latency: core 1 cycle (input edge -> registered write); crypto at least 2 cycles (push edge, then issue edge).
// Backpressure: core is never stalled; cu_ready = (count < DEPTH), and a same-edge pop earns no push credit.
//
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   core_we/core_rd/core_data      core writeback request (single cycle, highest priority)
//   cu_valid/cu_rd/cu_data         crypto result handshake (accepted when cu_ready)
//   cu_ready                       FIFO not full
//   reg_write/rd/write_data        registered regfile write port
//   pending_mask                   one bit per register targeted by any queued entry
//   fifo_count                     occupied FIFO entries
//   wb_conflict                    sticky: a core write hit a register still queued in the FIFO
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    core_we,
  input  logic [ADDR_W-1:0]       core_rd,
  input  logic [DATA_W-1:0]       core_data,
  input  logic                    cu_valid,
  input  logic [ADDR_W-1:0]       cu_rd,
  input  logic [DATA_W-1:0]       cu_data,
  output logic                    cu_ready,
  output logic                    reg_write,
  output logic [ADDR_W-1:0]       rd,
  output logic [DATA_W-1:0]       write_data,
  output logic [2**ADDR_W-1:0]    pending_mask,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    wb_conflict
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 2**ADDR_W;

  // FIFO storage; entries carry no reset, occupancy is tracked by r_valid/r_count
  logic [ADDR_W-1:0] r_mem_rd   [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic              r_reg_write;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_wdata;
  logic              r_conflict;

  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic [NREG-1:0]   w_mask;

  // Full/empty come from the count only, never from pointer comparison
  assign w_ready = (r_count < CW'(DEPTH));
  // Pop uses the count before this edge, so an entry pushed now cannot issue now
  assign w_push  = cu_valid && w_ready;
  assign w_pop   = !core_we && (r_count != '0);

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i]) begin
        w_mask[r_mem_rd[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wr_ptr]   <= cu_rd;
      r_mem_data[r_wr_ptr] <= cu_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Push and pop never target the same slot: push needs count<DEPTH, pop needs count>0
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_wdata     <= '0;
    end else if (core_we) begin
      r_reg_write <= 1'b1;
      r_rd        <= core_rd;
      r_wdata     <= core_data;
    end else if (w_pop) begin
      r_reg_write <= 1'b1;
      r_rd        <= r_mem_rd[r_rd_ptr];
      r_wdata     <= r_mem_data[r_rd_ptr];
    end else begin
      // Idle: drop the enable, keep index/data stable
      r_reg_write <= 1'b0;
    end
  end

  // Debug flag only; the core write still goes through, decode owns the stall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_conflict <= 1'b0;
    end else if (core_we && w_mask[core_rd]) begin
      r_conflict <= 1'b1;
    end
  end

  assign cu_ready     = w_ready;
  assign reg_write    = r_reg_write;
  assign rd           = r_rd;
  assign write_data   = r_wdata;
  assign pending_mask = w_mask;
  assign fifo_count   = r_count;
  assign wb_conflict  = r_conflict;

endmodule
